// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
// Drain stage for the 2x2 matrix multiplier. It captures c00..c11 on a
// start pulse and optionally clamps negative elements to zero (ReLU). It then
// streams the four elements in row-major order over a valid/ready
// interface with full backpressure.
module matrix_result_streamer #(
  parameter int DATA_W  = 128,
  parameter bit RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0][DATA_W-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0]       m_data_q, m_data_d;
  logic [1:0]              m_index_q, m_index_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [1:0]              next_index;
  logic                    handshake;

  // ReLU is applied once at capture so the stream path is a plain register.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    relu = (RELU_EN && x[DATA_W-1]) ? '0 : x;
  endfunction

  assign handshake  = m_valid_q & m_ready;
  assign next_index = m_index_q + 2'd1;

  // Next-state and next-output computation for the IDLE/SEND sequencer.
  always_comb begin
    // NOTE: every target gets a hold/default value first so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    cap_d     = cap_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cap_d[0]  = relu(c00);
          cap_d[1]  = relu(c01);
          cap_d[2]  = relu(c10);
          cap_d[3]  = relu(c11);
          m_data_d  = relu(c00);
          m_index_d = 2'd0;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          busy_d    = 1'b1;
          state_d   = SEND;
        end
      end

      SEND: begin
        // Without a handshake everything holds, so valid is never withdrawn.
        if (handshake) begin
          if (m_index_q == 2'd3) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_index_d = 2'd0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            m_index_d = next_index;
            m_data_d  = cap_q[next_index];
            m_last_d  = (next_index == 2'd3);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      // NOTE: the capture bank is reset as well, so a fresh reset never
      // leaves stale operands from an abandoned stream in the datapath.
      cap_q     <= '0;
      m_data_q  <= '0;
      m_index_q <= 2'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, which is what the _d logic above assumes.
      state_q   <= state_d;
      cap_q     <= cap_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_index = m_index_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: one instance with ReLU and one without,
// driven in lockstep. Expected beats go into a scoreboard queue when a burst
// is started. A negedge monitor pops and compares them on every transfer.
module tb_matrix_result_streamer;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst, start, m_ready;
  logic [W-1:0] c00, c01, c10, c11;

  logic [W-1:0] m_data, nr_data;
  logic         m_valid, nr_valid, m_last, nr_last;
  logic         busy, nr_busy, done, nr_done;
  logic [1:0]   m_index, nr_index;

  always #5 clk = ~clk;

  matrix_result_streamer #(.DATA_W(W), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_index(m_index), .m_last(m_last), .busy(busy), .done(done)
  );

  matrix_result_streamer #(.DATA_W(W), .RELU_EN(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .start(start),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .m_data(nr_data), .m_valid(nr_valid), .m_ready(m_ready),
    .m_index(nr_index), .m_last(nr_last), .busy(nr_busy), .done(nr_done)
  );

  typedef struct packed {
    logic [W-1:0] d_relu;
    logic [W-1:0] d_raw;
    logic [1:0]   idx;
  } beat_t;

  typedef struct packed {
    logic [3:0][W-1:0] c;    // c[0]=c00 .. c[3]=c11
    logic [3:0][W-1:0] exp;  // expected post-ReLU values
    logic [15:0]       rdy;  // m_ready per cycle, bit k = k-th cycle from start
    logic [7:0]        cyc;  // expected cycles from start to done
  } burst_t;

  int    checks   = 0;
  int    failures = 0;
  beat_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus stall-stability check, sampled mid-cycle.
  beat_t        mon_e;
  logic         prev_stall = 1'b0;
  logic [W-1:0] held_data;
  logic [1:0]   held_index;

  always @(negedge clk) begin
    if (rst !== 1'b1 && m_valid === 1'b1 && prev_stall) begin
      check("stall_data_stable", m_data, held_data);
      check("stall_index_stable", W'(m_index), W'(held_index));
    end
    if (rst !== 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", W'(m_valid), W'(0));
      end else begin
        mon_e = sb.pop_front();
        check("beat_data", m_data, mon_e.d_relu);
        check("beat_index", W'(m_index), W'(mon_e.idx));
        check("beat_last", W'(m_last), W'(mon_e.idx == 2'd3));
        check("nr_valid", W'(nr_valid), W'(1));
        check("nr_data", nr_data, mon_e.d_raw);
        check("nr_index", W'(nr_index), W'(mon_e.idx));
      end
    end
    prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
    held_data  = m_data;
    held_index = m_index;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a burst, scrambles the inputs right after capture, and follows
  // the ready pattern until done.
  task automatic run_burst(input burst_t b, input string tag);
    int cyc;
    c00 = b.c[0]; c01 = b.c[1]; c10 = b.c[2]; c11 = b.c[3];
    start   = 1'b1;
    m_ready = b.rdy[0];
    for (int i = 0; i < 4; i++) sb.push_back({b.exp[i], b.c[i], 2'(i)});
    step();
    start = 1'b0;
    c00 = ~b.c[0]; c01 = ~b.c[1]; c10 = ~b.c[2]; c11 = ~b.c[3];
    check({tag, "_busy_on"}, W'(busy), W'(1));
    check({tag, "_valid_on"}, W'(m_valid), W'(1));
    check({tag, "_done_low"}, W'(done), W'(0));
    check({tag, "_first_index"}, W'(m_index), W'(0));
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      m_ready = b.rdy[cyc[3:0]];
      step();
      cyc++;
    end
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_cycles"}, W'(cyc), W'(b.cyc));
    check({tag, "_busy_off"}, W'(busy), W'(0));
    check({tag, "_valid_off"}, W'(m_valid), W'(0));
    check({tag, "_drained"}, W'(sb.size()), W'(0));
  endtask

  burst_t       tbl [4];
  logic [W-1:0] neg10, minv, maxv, allones;
  int           n;

  initial begin
    neg10   = ~W'(9);
    minv    = {1'b1, {(W-1){1'b0}}};
    maxv    = {1'b0, {(W-1){1'b1}}};
    allones = {W{1'b1}};

    // Basic stream, full throughput.
    tbl[0] = '{c: {W'(50), W'(43), W'(22), W'(19)},
               exp: {W'(50), W'(43), W'(22), W'(19)},
               rdy: 16'hFFFF, cyc: 8'd5};
    // Backpressure: ready 1,0,0,1,1,0,1 then high.
    tbl[1] = '{c: {W'(50), W'(43), W'(22), W'(19)},
               exp: {W'(50), W'(43), W'(22), W'(19)},
               rdy: 16'hFFD9, cyc: 8'd8};
    // ReLU on a negative element; zero passes unchanged.
    tbl[2] = '{c: {W'(0), W'(9), neg10, W'(7)},
               exp: {W'(0), W'(9), W'(0), W'(7)},
               rdy: 16'hFFFF, cyc: 8'd5};
    // Sign-boundary values under alternating ready.
    tbl[3] = '{c: {W'(1), allones, maxv, minv},
               exp: {W'(1), W'(0), maxv, W'(0)},
               rdy: 16'h5555, cyc: 8'd9};

    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0;
    repeat (3) step();
    check("rst_valid", W'(m_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_data", m_data, W'(0));
    check("rst_index", W'(m_index), W'(0));
    check("rst_last", W'(m_last), W'(0));
    check("rst_nr_data", nr_data, W'(0));
    rst = 1'b0;
    step();

    // Start while busy is ignored; inputs change after capture.
    c00 = W'(11); c01 = W'(12); c10 = W'(13); c11 = W'(14);
    start = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({W'(11 + i), W'(11 + i), 2'(i)});
    step();
    start = 1'b0;
    c00 = W'(100); c01 = W'(101); c10 = W'(102); c11 = W'(103);
    step();
    start = 1'b1;
    c00 = W'(200); c01 = W'(201); c10 = W'(202); c11 = W'(203);
    step();
    start = 1'b0;
    check("busy_start_still_busy", W'(busy), W'(1));
    check("busy_start_index", W'(m_index), W'(2));
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("busy_start_done", W'(done), W'(1));
    check("busy_start_cycles", W'(n), W'(2));
    check("busy_start_drained", W'(sb.size()), W'(0));

    // Table bursts back to back, each started in the previous done cycle.
    for (int t = 0; t < 4; t++) run_burst(tbl[t], $sformatf("burst%0d", t));

    // Reset mid-stream after the second transfer, together with start.
    c00 = W'(1); c01 = W'(2); c10 = W'(3); c11 = W'(4);
    start = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({W'(1 + i), W'(1 + i), 2'(i)});
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_index", W'(m_index), W'(2));
    rst = 1'b1; start = 1'b1; m_ready = 1'b0;
    step();
    check("mid_rst_valid", W'(m_valid), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_data", m_data, W'(0));
    check("mid_rst_nr_valid", W'(nr_valid), W'(0));
    rst = 1'b0; start = 1'b0; m_ready = 1'b1;
    repeat (6) step();
    check("post_rst_valid", W'(m_valid), W'(0));
    check("post_rst_busy", W'(busy), W'(0));
    check("post_rst_pending", W'(sb.size()), W'(2));
    sb.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
